// File: rtl/ili9341_frame_scaler_if.sv
// Pixel stream towards the ILI9341 controller and read bus towards the image ROM.
interface ili9341_frame_scaler_if #(
   parameter int PIXEL_SIZE = 16,
   parameter int ADDR_W     = 15
);
   logic [ADDR_W-1:0]     mem_addr;
   logic [PIXEL_SIZE-1:0] mem_data;
   logic [PIXEL_SIZE-1:0] pix_data;
   logic                  pix_valid;
   logic                  pix_ready;
   logic                  frame_start;
   logic                  frame_done;

   modport master (
      output mem_addr,
      input  mem_data,
      output pix_data,
      output pix_valid,
      input  pix_ready,
      output frame_start,
      output frame_done
   );

   modport slave (
      input  mem_addr,
      output mem_data,
      input  pix_data,
      input  pix_valid,
      output pix_ready,
      input  frame_start,
      input  frame_done
   );
endinterface

// File: rtl/ili9341_frame_scaler.sv
// Streams one upscaled ROM image (or solid fill) per frame to the ILI9341 controller.
// Optional ILI9341_TEST_PATTERN_EN: img_sel == NUM_IMAGES emits an 8-bar colour pattern.
module ili9341_frame_scaler #(
   parameter int SRC_W      = 80,
   parameter int SRC_H      = 80,
   parameter int SCALE      = 3,
   parameter int PIXEL_SIZE = 16,
   parameter int NUM_IMAGES = 5,
   parameter int SEL_W      = 3,
   parameter int ADDR_W     = $clog2(NUM_IMAGES * SRC_W * SRC_H)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [SEL_W-1:0]      img_sel,
   input  logic                  fill_en,
   input  logic [PIXEL_SIZE-1:0] fill_color,
   input  logic                  refresh,
   ili9341_frame_scaler_if.master bus
);

   localparam int XW = (SRC_W > 1) ? $clog2(SRC_W) : 1;
   localparam int YW = (SRC_H > 1) ? $clog2(SRC_H) : 1;
   localparam int KW = (SCALE > 1) ? $clog2(SCALE) : 1;
   localparam logic [XW-1:0]     X_LAST    = XW'(SRC_W - 1);
   localparam logic [YW-1:0]     Y_LAST    = YW'(SRC_H - 1);
   localparam logic [KW-1:0]     K_LAST    = KW'(SCALE - 1);
   localparam logic [ADDR_W-1:0] IMG_WORDS = ADDR_W'(SRC_W * SRC_H);
   localparam logic [ADDR_W-1:0] ROW_WORDS = ADDR_W'(SRC_W);
   localparam logic [31:0]       NUM_IMG_V = 32'(NUM_IMAGES);

`ifdef ILI9341_TEST_PATTERN_EN
   localparam int unsigned DST_W = int unsigned'(SRC_W * SCALE);

   function automatic logic [PIXEL_SIZE-1:0] bar_color(input logic [XW-1:0] col,
                                                       input logic [KW-1:0] rep);
      int unsigned x;
      logic [15:0] c;
      x = 32'(col) * int unsigned'(SCALE) + 32'(rep);
      case ((x * 8) / DST_W)
         0:       c = 16'hF800;
         1:       c = 16'h07E0;
         2:       c = 16'h001F;
         3:       c = 16'hFFE0;
         4:       c = 16'hF81F;
         5:       c = 16'h07FF;
         6:       c = 16'hFFFF;
         default: c = 16'h0000;
      endcase
      return PIXEL_SIZE'(c);
   endfunction
`endif

   typedef enum logic [1:0] {S_FETCH, S_WAIT, S_OUT, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [XW-1:0]         sx_q, sx_d;
   logic [YW-1:0]         sy_q, sy_d;
   logic [KW-1:0]         kx_q, kx_d;
   logic [KW-1:0]         ky_q, ky_d;
   logic [SEL_W-1:0]      sel_l_q, sel_l_d;
   logic                  fill_l_q, fill_l_d;
   logic [PIXEL_SIZE-1:0] color_l_q, color_l_d;
   logic                  start_q, start_d;
   logic                  first_q, first_d;
   logic [PIXEL_SIZE-1:0] pix_data_q, pix_data_d;
   logic                  pix_valid_q, pix_valid_d;
   logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
   logic                  frame_start_q, frame_start_d;
   logic                  frame_done_q, frame_done_d;

   logic sel_oob;
   logic pat_mode;
   logic fill_mode;
   logic no_rom;
   logic handshake;
   logic relaunch;

   // Mode is derived from the latched selection so a mid-frame input change cannot tear a frame.
   always_comb begin
      sel_oob = (32'(sel_l_q) >= NUM_IMG_V);
`ifdef ILI9341_TEST_PATTERN_EN
      pat_mode = !fill_l_q && (32'(sel_l_q) == NUM_IMG_V);
`else
      pat_mode = 1'b0;
`endif
      fill_mode = fill_l_q || (sel_oob && !pat_mode);
      no_rom    = fill_mode || pat_mode;
      handshake = pix_valid_q && bus.pix_ready;
      relaunch  = start_q || refresh || (img_sel != sel_l_q) || (fill_en != fill_l_q) ||
                  (fill_en && (fill_color != color_l_q));
   end

   always_comb begin
      state_d       = state_q;
      sx_d          = sx_q;
      sy_d          = sy_q;
      kx_d          = kx_q;
      ky_d          = ky_q;
      sel_l_d       = sel_l_q;
      fill_l_d      = fill_l_q;
      color_l_d     = color_l_q;
      start_d       = start_q;
      first_d       = first_q;
      pix_data_d    = pix_data_q;
      pix_valid_d   = pix_valid_q;
      frame_start_d = 1'b0;

      unique case (state_q)
         S_DONE: begin
            if (relaunch) begin
               state_d   = S_FETCH;
               sel_l_d   = img_sel;
               fill_l_d  = fill_en;
               color_l_d = fill_color;
               start_d   = 1'b0;
               first_d   = 1'b1;
            end
         end
         S_FETCH: begin
            if (no_rom) begin
               state_d     = S_OUT;
               pix_valid_d = 1'b1;
`ifdef ILI9341_TEST_PATTERN_EN
               pix_data_d  = pat_mode ? bar_color(sx_q, kx_q) : color_l_q;
`else
               pix_data_d  = color_l_q;
`endif
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            state_d     = S_OUT;
            pix_valid_d = 1'b1;
            pix_data_d  = bus.mem_data;
         end
         S_OUT: begin
            if (handshake) begin
               first_d       = 1'b0;
               frame_start_d = first_q;
               if (kx_q != K_LAST) begin
                  // Horizontal repeat reuses the held pixel; only the test pattern may vary within it.
                  kx_d = kx_q + 1'b1;
`ifdef ILI9341_TEST_PATTERN_EN
                  if (pat_mode) pix_data_d = bar_color(sx_q, kx_d);
`endif
               end else begin
                  kx_d        = '0;
                  pix_valid_d = 1'b0;
                  if ((sx_q == X_LAST) && (sy_q == Y_LAST) && (ky_q == K_LAST)) begin
                     state_d = S_DONE;
                     sx_d    = '0;
                     sy_d    = '0;
                     ky_d    = '0;
                  end else begin
                     state_d = S_FETCH;
                     if (sx_q != X_LAST) begin
                        sx_d = sx_q + 1'b1;
                     end else begin
                        sx_d = '0;
                        if (ky_q != K_LAST) begin
                           ky_d = ky_q + 1'b1;
                        end else begin
                           ky_d = '0;
                           sy_d = sy_q + 1'b1;
                        end
                     end
                  end
               end
            end
         end
         default: state_d = S_DONE;
      endcase

      frame_done_d = (state_d == S_DONE);
      mem_addr_d   = ADDR_W'(sel_l_d) * IMG_WORDS + ADDR_W'(sy_d) * ROW_WORDS + ADDR_W'(sx_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_DONE;
         sx_q          <= '0;
         sy_q          <= '0;
         kx_q          <= '0;
         ky_q          <= '0;
         sel_l_q       <= '0;
         fill_l_q      <= 1'b0;
         color_l_q     <= '0;
         start_q       <= 1'b1;
         first_q       <= 1'b0;
         pix_data_q    <= '0;
         pix_valid_q   <= 1'b0;
         mem_addr_q    <= '0;
         frame_start_q <= 1'b0;
         frame_done_q  <= 1'b1;
      end else begin
         state_q       <= state_d;
         sx_q          <= sx_d;
         sy_q          <= sy_d;
         kx_q          <= kx_d;
         ky_q          <= ky_d;
         sel_l_q       <= sel_l_d;
         fill_l_q      <= fill_l_d;
         color_l_q     <= color_l_d;
         start_q       <= start_d;
         first_q       <= first_d;
         pix_data_q    <= pix_data_d;
         pix_valid_q   <= pix_valid_d;
         mem_addr_q    <= mem_addr_d;
         frame_start_q <= frame_start_d;
         frame_done_q  <= frame_done_d;
      end
   end

   assign bus.mem_addr    = mem_addr_q;
   assign bus.pix_data    = pix_data_q;
   assign bus.pix_valid   = pix_valid_q;
   assign bus.frame_start = frame_start_q;
   assign bus.frame_done  = frame_done_q;

endmodule

// File: tb/tb_ili9341_frame_scaler.sv
// Directed bench for ili9341_frame_scaler with a 4x2 source, x2 scale, 2 images, ROM[i] = i.
module tb_ili9341_frame_scaler;

   logic        clk        = 1'b0;
   logic        rst        = 1'b1;
   logic [2:0]  img_sel    = '0;
   logic        fill_en    = 1'b0;
   logic [15:0] fill_color = '0;
   logic        refresh    = 1'b0;

   int total  = 0;
   int bad    = 0;
   int starts = 0;
   logic [15:0] got[$];

   ili9341_frame_scaler_if #(.PIXEL_SIZE(16), .ADDR_W(4)) bus ();

   ili9341_frame_scaler #(
      .SRC_W(4), .SRC_H(2), .SCALE(2), .PIXEL_SIZE(16),
      .NUM_IMAGES(2), .SEL_W(3), .ADDR_W(4)
   ) dut (
      .clk(clk), .rst(rst), .img_sel(img_sel), .fill_en(fill_en),
      .fill_color(fill_color), .refresh(refresh), .bus(bus)
   );

   always #5 clk = ~clk;

   // ROM with one cycle read latency, content equal to its address
   always @(posedge clk) bus.mem_data <= {12'h000, bus.mem_addr};

   always @(negedge clk) begin
      if (bus.pix_valid === 1'b1 && bus.pix_ready === 1'b1) got.push_back(bus.pix_data);
      if (bus.frame_start === 1'b1) starts++;
   end

   function automatic logic [15:0] img_px(input int sel, input int i);
      return 16'(sel * 8 + (i / 16) * 4 + (i % 8) / 2);
   endfunction

   function automatic logic [15:0] bar_px(input int x);
      case (x)
         0: return 16'hF800;
         1: return 16'h07E0;
         2: return 16'h001F;
         3: return 16'hFFE0;
         4: return 16'hF81F;
         5: return 16'h07FF;
         6: return 16'hFFFF;
         default: return 16'h0000;
      endcase
   endfunction

   function automatic logic [15:0] got_at(input int idx);
      if (idx < got.size()) return got[idx];
      return 16'hxxxx;
   endfunction

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_done(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         cyc(1);
         if (bus.frame_done === 1'b1) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      cyc(3);
      total++; if (bus.pix_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.pix_valid); end
      total++; if (bus.pix_data !== 16'h0) begin bad++; $display("FAIL rst_data got=%h exp=0000", bus.pix_data); end
      total++; if (bus.mem_addr !== 4'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", bus.mem_addr); end
      total++; if (bus.frame_start !== 1'b0) begin bad++; $display("FAIL rst_start got=%b exp=0", bus.frame_start); end
      total++; if (bus.frame_done !== 1'b1) begin bad++; $display("FAIL rst_done got=%b exp=1", bus.frame_done); end
      rst = 1'b0;
      cyc(1);
      total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL autostart_done got=%b exp=0", bus.frame_done); end
   endtask

   task automatic test_image0;
      int b;
      int s;
      bit ok;
      b = got.size();
      s = starts;
      wait_done(200, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL img0_timeout got=%b exp=1", ok); end
      total++; if (got.size() - b !== 32) begin bad++; $display("FAIL img0_count got=%0d exp=32", got.size() - b); end
      for (int i = 0; i < 32; i++) begin
         total++;
         if (got_at(b + i) !== img_px(0, i)) begin bad++; $display("FAIL img0_px[%0d] got=%h exp=%h", i, got_at(b + i), img_px(0, i)); end
      end
      total++; if (starts - s !== 1) begin bad++; $display("FAIL img0_starts got=%0d exp=1", starts - s); end
   endtask

   task automatic test_sel_change;
      int b;
      int s;
      bit ok;
      b = got.size();
      s = starts;
      img_sel = 3'd1;
      cyc(1);
      total++; if (bus.mem_addr !== 4'd8) begin bad++; $display("FAIL sel_addr got=%0d exp=8", bus.mem_addr); end
      total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL sel_done got=%b exp=0", bus.frame_done); end
      cyc(1);
      total++; if (bus.pix_valid !== 1'b0) begin bad++; $display("FAIL sel_lat1 got=%b exp=0", bus.pix_valid); end
      cyc(1);
      total++; if ({bus.pix_valid, bus.pix_data} !== {1'b1, 16'd8}) begin bad++; $display("FAIL sel_lat2 got=%b/%h exp=1/0008", bus.pix_valid, bus.pix_data); end
      wait_done(200, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL sel_timeout got=%b exp=1", ok); end
      total++; if (got.size() - b !== 32) begin bad++; $display("FAIL sel_count got=%0d exp=32", got.size() - b); end
      for (int i = 0; i < 32; i++) begin
         total++;
         if (got_at(b + i) !== img_px(1, i)) begin bad++; $display("FAIL sel_px[%0d] got=%h exp=%h", i, got_at(b + i), img_px(1, i)); end
      end
      total++; if (starts - s !== 1) begin bad++; $display("FAIL sel_starts got=%0d exp=1", starts - s); end
   endtask

   task automatic test_midframe_toggle;
      int b;
      bit ok;
      bit stayed;
      b = got.size();
      refresh = 1'b1;
      cyc(1);
      refresh = 1'b0;
      total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL tog_refresh got=%b exp=0", bus.frame_done); end
      cyc(12);
      img_sel = 3'd0;
      wait_done(200, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL tog_timeout1 got=%b exp=1", ok); end
      total++; if (got.size() - b !== 32) begin bad++; $display("FAIL tog_count1 got=%0d exp=32", got.size() - b); end
      for (int i = 0; i < 32; i++) begin
         total++;
         if (got_at(b + i) !== img_px(1, i)) begin bad++; $display("FAIL tog_old_px[%0d] got=%h exp=%h", i, got_at(b + i), img_px(1, i)); end
      end
      b = got.size();
      cyc(1);
      total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL tog_newframe got=%b exp=0", bus.frame_done); end
      cyc(8);
      refresh = 1'b1;
      cyc(1);
      refresh = 1'b0;
      wait_done(200, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL tog_timeout2 got=%b exp=1", ok); end
      total++; if (got.size() - b !== 32) begin bad++; $display("FAIL tog_count2 got=%0d exp=32", got.size() - b); end
      for (int i = 0; i < 32; i++) begin
         total++;
         if (got_at(b + i) !== img_px(0, i)) begin bad++; $display("FAIL tog_new_px[%0d] got=%h exp=%h", i, got_at(b + i), img_px(0, i)); end
      end
      stayed = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cyc(1);
         if (bus.frame_done !== 1'b1) stayed = 1'b0;
      end
      total++; if (stayed !== 1'b1) begin bad++; $display("FAIL tog_no_extra got=%b exp=1", stayed); end
   endtask

   task automatic test_backpressure;
      int b;
      int n;
      bit ok;
      logic [15:0] exp_px;
      b = got.size();
      refresh = 1'b1;
      cyc(1);
      refresh = 1'b0;
      for (int i = 0; i < 100 && got.size() - b < 5; i++) cyc(1);
      bus.pix_ready = 1'b0;
      for (int i = 0; i < 10 && bus.pix_valid !== 1'b1; i++) cyc(1);
      n = got.size() - b;
      exp_px = img_px(0, n);
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         total++;
         if ({bus.pix_valid, bus.pix_data} !== {1'b1, exp_px}) begin bad++; $display("FAIL bp_hold[%0d] got=%b/%h exp=1/%h", i, bus.pix_valid, bus.pix_data, exp_px); end
      end
      bus.pix_ready = 1'b1;
      wait_done(200, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL bp_timeout got=%b exp=1", ok); end
      total++; if (got.size() - b !== 32) begin bad++; $display("FAIL bp_count got=%0d exp=32", got.size() - b); end
      for (int i = 0; i < 32; i++) begin
         total++;
         if (got_at(b + i) !== img_px(0, i)) begin bad++; $display("FAIL bp_px[%0d] got=%h exp=%h", i, got_at(b + i), img_px(0, i)); end
      end
   endtask

   task automatic test_fill;
      int b;
      bit ok;
      logic [15:0] exp_px;
      b = got.size();
      fill_color = 16'hF800;
      fill_en = 1'b1;
      cyc(1);
      total++; if ({bus.pix_valid, bus.frame_done} !== 2'b00) begin bad++; $display("FAIL fill_fetch got=%b exp=00", {bus.pix_valid, bus.frame_done}); end
      cyc(1);
      total++; if ({bus.pix_valid, bus.pix_data} !== {1'b1, 16'hF800}) begin bad++; $display("FAIL fill_lat got=%b/%h exp=1/f800", bus.pix_valid, bus.pix_data); end
      wait_done(200, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL fill_timeout got=%b exp=1", ok); end
      total++; if (got.size() - b !== 32) begin bad++; $display("FAIL fill_count got=%0d exp=32", got.size() - b); end
      for (int i = 0; i < 32; i++) begin
         total++;
         if (got_at(b + i) !== 16'hF800) begin bad++; $display("FAIL fill_px[%0d] got=%h exp=f800", i, got_at(b + i)); end
      end

      b = got.size();
      fill_en = 1'b0;
      img_sel = 3'd3;
      fill_color = 16'h07E0;
      cyc(1);
      total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL oob_start got=%b exp=0", bus.frame_done); end
      wait_done(200, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL oob_timeout got=%b exp=1", ok); end
      total++; if (got.size() - b !== 32) begin bad++; $display("FAIL oob_count got=%0d exp=32", got.size() - b); end
      for (int i = 0; i < 32; i++) begin
         total++;
         if (got_at(b + i) !== 16'h07E0) begin bad++; $display("FAIL oob_px[%0d] got=%h exp=07e0", i, got_at(b + i)); end
      end

      b = got.size();
      img_sel = 3'd2;
      fill_color = 16'h001F;
      cyc(1);
      wait_done(200, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL sel2_timeout got=%b exp=1", ok); end
      total++; if (got.size() - b !== 32) begin bad++; $display("FAIL sel2_count got=%0d exp=32", got.size() - b); end
      for (int i = 0; i < 32; i++) begin
`ifdef ILI9341_TEST_PATTERN_EN
         exp_px = bar_px(i % 8);
`else
         exp_px = 16'h001F;
`endif
         total++;
         if (got_at(b + i) !== exp_px) begin bad++; $display("FAIL sel2_px[%0d] got=%h exp=%h", i, got_at(b + i), exp_px); end
      end
   endtask

   task automatic test_reset_midframe;
      int b;
      bit ok;
      b = got.size();
      img_sel = 3'd0;
      cyc(1);
      for (int i = 0; i < 100 && got.size() - b < 10; i++) cyc(1);
      rst = 1'b1;
      cyc(1);
      total++; if ({bus.pix_valid, bus.frame_done} !== 2'b01) begin bad++; $display("FAIL midrst_out got=%b exp=01", {bus.pix_valid, bus.frame_done}); end
      cyc(1);
      rst = 1'b0;
      b = got.size();
      cyc(1);
      total++; if ({bus.frame_done, bus.mem_addr} !== {1'b0, 4'h0}) begin bad++; $display("FAIL midrst_restart got=%b/%h exp=0/0", bus.frame_done, bus.mem_addr); end
      wait_done(200, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL midrst_timeout got=%b exp=1", ok); end
      total++; if (got.size() - b !== 32) begin bad++; $display("FAIL midrst_count got=%0d exp=32", got.size() - b); end
      for (int i = 0; i < 32; i++) begin
         total++;
         if (got_at(b + i) !== img_px(0, i)) begin bad++; $display("FAIL midrst_px[%0d] got=%h exp=%h", i, got_at(b + i), img_px(0, i)); end
      end
   endtask

   initial begin
      bus.pix_ready = 1'b1;
      test_reset;
      test_image0;
      test_sel_change;
      test_midframe_toggle;
      test_backpressure;
      test_fill;
      test_reset_midframe;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
